// File: rtl/ptosda_n_if.sv
// Bus bundle for the ptosda_n serialiser: load handshake, status flags and the scl/sda pair.
interface ptosda_n_if #(
    parameter int unsigned DATA_W = 4
);
    logic [DATA_W-1:0] data;
    logic              load;
    logic              ready;
    logic              busy;
    logic              done;
    logic              scl;
    logic              sda;

    modport master (
        output data,
        output load,
        input  ready,
        input  busy,
        input  done,
        input  scl,
        input  sda
    );

    modport slave (
        input  data,
        input  load,
        output ready,
        output busy,
        output done,
        output scl,
        output sda
    );
endinterface

// File: rtl/ptosda_n.sv
// Parallel-to-serial framer: start, DATA_W bits MSB first, stop, on a free-running divided scl.
// Define PTOSDA_PARITY_EN to append an even parity bit after the data word.
module ptosda_n #(
    parameter int unsigned DATA_W   = 4,
    parameter int unsigned HALF_DIV = 1
) (
    input  logic      sclk,
    input  logic      rst,
    ptosda_n_if.slave bus
);
    localparam int unsigned BIT_W = $clog2(DATA_W + 1);
    localparam int unsigned CNT_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(HALF_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

`ifdef PTOSDA_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP_LO, STOP_HI, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP_LO, STOP_HI, DONE} state_t;
`endif

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt;
    logic              scl_q;
    logic [DATA_W-1:0] shift, shift_d;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_d;
    logic              sda_q, sda_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef PTOSDA_PARITY_EN
    logic              par_q, par_d;
`endif
    logic              high_first_c;
    logic              low_first_c;

    // Free-running scl divider, independent of frame activity
    always_ff @(posedge sclk) begin
        if (rst) begin
            cnt   <= '0;
            scl_q <= 1'b1;
        end else if (cnt == CNT_MAX) begin
            cnt   <= '0;
            scl_q <= ~scl_q;
        end else begin
            cnt   <= cnt + CNT_W'(1);
        end
    end

    assign high_first_c = scl_q  && (cnt == '0);
    assign low_first_c  = !scl_q && (cnt == '0);

    always_comb begin
        state_d   = state;
        shift_d   = shift;
        bit_cnt_d = bit_cnt;
        sda_d     = sda_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef PTOSDA_PARITY_EN
        par_d     = par_q;
`endif
        case (state)
            IDLE: begin
                ready_d = 1'b1;
                sda_d   = 1'b1;
                if (bus.load && ready_q) begin
                    shift_d   = bus.data;
                    bit_cnt_d = '0;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = START;
`ifdef PTOSDA_PARITY_EN
                    par_d     = ^bus.data;
`endif
                end
            end
            // sda falls while scl is still high
            START: begin
                if (high_first_c) begin
                    sda_d   = 1'b0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (low_first_c) begin
                    sda_d     = shift[DATA_W-1];
                    shift_d   = {shift[DATA_W-2:0], 1'b0};
                    bit_cnt_d = bit_cnt + BIT_W'(1);
                    if (bit_cnt == BIT_LAST) begin
`ifdef PTOSDA_PARITY_EN
                        state_d = PAR;
`else
                        state_d = STOP_LO;
`endif
                    end
                end
            end
`ifdef PTOSDA_PARITY_EN
            PAR: begin
                if (low_first_c) begin
                    sda_d   = par_q;
                    state_d = STOP_LO;
                end
            end
`endif
            STOP_LO: begin
                if (low_first_c) begin
                    sda_d   = 1'b0;
                    state_d = STOP_HI;
                end
            end
            // sda rises while scl is high, closing the frame
            STOP_HI: begin
                if (high_first_c) begin
                    sda_d   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state   <= IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            sda_q   <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PTOSDA_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state   <= state_d;
            shift   <= shift_d;
            bit_cnt <= bit_cnt_d;
            sda_q   <= sda_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef PTOSDA_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign bus.scl   = scl_q;
    assign bus.sda   = sda_q;
    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_ptosda_n.sv
// Bench for ptosda_n: a 4-bit/HALF_DIV=1 unit and an 8-bit/HALF_DIV=3 unit, scoreboarded per scl rising edge.
module tb_ptosda_n;
    logic sclk = 1'b0;
    logic rst  = 1'b1;
    always #5 sclk = ~sclk;

    ptosda_n_if #(.DATA_W(4)) bus4 ();
    ptosda_n_if #(.DATA_W(8)) bus8 ();

    ptosda_n #(.DATA_W(4), .HALF_DIV(1)) u4 (.sclk(sclk), .rst(rst), .bus(bus4));
    ptosda_n #(.DATA_W(8), .HALF_DIV(3)) u8 (.sclk(sclk), .rst(rst), .bus(bus8));

    int   n_cmp = 0;
    int   n_err = 0;
    int   starts [2] = '{0, 0};
    int   stops  [2] = '{0, 0};
    int   strays [2] = '{0, 0};
    int   dones  [2] = '{0, 0};
    logic obs4 [$];
    logic obs8 [$];
    logic exp4 [$];
    logic exp8 [$];
    int   rd4 = 0;
    int   rd8 = 0;

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic f_scl(input int u);   return (u == 0) ? bus4.scl   : bus8.scl;   endfunction
    function automatic logic f_sda(input int u);   return (u == 0) ? bus4.sda   : bus8.sda;   endfunction
    function automatic logic f_done(input int u);  return (u == 0) ? bus4.done  : bus8.done;  endfunction
    function automatic logic f_busy(input int u);  return (u == 0) ? bus4.busy  : bus8.busy;  endfunction
    function automatic logic f_ready(input int u); return (u == 0) ? bus4.ready : bus8.ready; endfunction

    function automatic int obs_size(input int u);
        return (u == 0) ? obs4.size() : obs8.size();
    endfunction

    function automatic logic obs_at(input int u, input int i);
        if (u == 0) return (i < obs4.size()) ? obs4[i] : 1'bx;
        return (i < obs8.size()) ? obs8[i] : 1'bx;
    endfunction

    // Line monitor: classifies sda edges relative to the previous scl level and records sda at scl rises
    task automatic mon(input int u);
        logic ps = 1'b1;
        logic pd = 1'b1;
        logic pr = 1'b1;
        logic st = 1'b0;
        logic c;
        logic s;
        forever begin
            @(negedge sclk);
            c = f_scl(u);
            s = f_sda(u);
            if (rst || pr) begin
                st = 1'b0;
            end else begin
                if (f_done(u)) dones[u]++;
                if (ps && (s !== pd)) begin
                    if (!s && !st) begin
                        st = 1'b1;
                        starts[u]++;
                    end else if (s && st) begin
                        st = 1'b0;
                        stops[u]++;
                    end else begin
                        strays[u]++;
                    end
                end
                if (st && !ps && c) begin
                    if (u == 0) obs4.push_back(s);
                    else        obs8.push_back(s);
                end
            end
            ps = c;
            pd = s;
            pr = rst;
        end
    endtask

    initial mon(0);
    initial mon(1);

    task automatic load_frame(input int u, input logic [7:0] d);
        int k = 0;
        while (f_ready(u) !== 1'b1 && k < 100) begin
            tick();
            k++;
        end
        chk($sformatf("u%0d_ready_before_load", u), 32'(f_ready(u)), 32'd1);
        if (u == 0) begin
            bus4.data = d[3:0];
            bus4.load = 1'b1;
            for (int i = 3; i >= 0; i--) exp4.push_back(d[i]);
            exp4.push_back(1'b0);
        end else begin
            bus8.data = d;
            bus8.load = 1'b1;
            for (int i = 7; i >= 0; i--) exp8.push_back(d[i]);
`ifdef PTOSDA_PARITY_EN
            exp8.push_back(^d);
`endif
            exp8.push_back(1'b0);
        end
        tick();
        bus4.load = 1'b0;
        bus8.load = 1'b0;
        chk($sformatf("u%0d_busy_after_accept", u), 32'(f_busy(u)), 32'd1);
        chk($sformatf("u%0d_ready_after_accept", u), 32'(f_ready(u)), 32'd0);
    endtask

    task automatic wait_frame(input int u, input string tag);
        int   k = 0;
        int   n = 0;
        int   base;
        logic e;
        while (f_done(u) !== 1'b1 && k < 400) begin
            tick();
            k++;
        end
        chk({tag, "_done"}, 32'(f_done(u)), 32'd1);
        chk({tag, "_busy_at_done"}, 32'(f_busy(u)), 32'd0);
        base = (u == 0) ? rd4 : rd8;
        if (u == 0) begin
            while (exp4.size() > 0) begin
                e = exp4.pop_front();
                chk($sformatf("%s_bit%0d", tag, n), 32'(obs_at(0, base + n)), 32'(e));
                n++;
            end
            rd4 = base + n;
        end else begin
            while (exp8.size() > 0) begin
                e = exp8.pop_front();
                chk($sformatf("%s_bit%0d", tag, n), 32'(obs_at(1, base + n)), 32'(e));
                n++;
            end
            rd8 = base + n;
        end
        chk({tag, "_nsamp"}, 32'(obs_size(u) - base), 32'(n));
        tick();
        chk({tag, "_ready_after_done"}, 32'(f_ready(u)), 32'd1);
    endtask

    initial begin
        int   d0;
        int   s0;
        int   p0;
        int   k;
        int   t;
        int   h;
        logic p;

        bus4.data = '0;
        bus4.load = 1'b0;
        bus8.data = '0;
        bus8.load = 1'b0;
        repeat (3) tick();

        chk("rst_u4_scl",   32'(bus4.scl),   32'd1);
        chk("rst_u4_sda",   32'(bus4.sda),   32'd1);
        chk("rst_u4_ready", 32'(bus4.ready), 32'd0);
        chk("rst_u4_busy",  32'(bus4.busy),  32'd0);
        chk("rst_u4_done",  32'(bus4.done),  32'd0);
        chk("rst_u8_scl",   32'(bus8.scl),   32'd1);
        chk("rst_u8_sda",   32'(bus8.sda),   32'd1);
        chk("rst_u8_ready", 32'(bus8.ready), 32'd0);

        rst = 1'b0;
        tick();
        chk("u4_ready_after_rst", 32'(bus4.ready), 32'd1);
        chk("u8_ready_after_rst", 32'(bus8.ready), 32'd1);

        load_frame(0, 8'h0A);
        wait_frame(0, "f1010");
        chk("f1010_one_done", 32'(dones[0]), 32'd1);

        k = 0;
        do begin p = bus8.scl; tick(); k++; end while (!(p === 1'b0 && bus8.scl === 1'b1) && k < 50);
        t = 0;
        do begin p = bus8.scl; tick(); t++; end while (!(p === 1'b0 && bus8.scl === 1'b1) && t < 50);
        chk("u8_scl_period", 32'(t), 32'd6);
        h = 0;
        while (bus8.scl === 1'b1 && h < 50) begin tick(); h++; end
        chk("u8_scl_high_len", 32'(h), 32'd3);

        load_frame(1, 8'hA5);
        wait_frame(1, "fA5");
        load_frame(1, 8'h01);
        wait_frame(1, "f01");
        chk("u8_dones", 32'(dones[1]), 32'd2);

        d0 = dones[0];
        load_frame(0, 8'h0F);
        repeat (3) tick();
        bus4.data = 4'h0;
        bus4.load = 1'b1;
        chk("busy_load_ready_low", 32'(bus4.ready), 32'd0);
        tick();
        bus4.load = 1'b0;
        wait_frame(0, "fF");
        s0 = starts[0];
        repeat (30) tick();
        chk("fF_no_second_frame", 32'(starts[0]), 32'(s0));
        chk("fF_one_done", 32'(dones[0]), 32'(d0 + 1));

        load_frame(0, 8'h0C);
        tick();
        bus4.data = 4'h0;
        wait_frame(0, "fC");

        d0 = dones[0];
        p0 = stops[0];
        load_frame(0, 8'h09);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        chk("abort_scl",   32'(bus4.scl),   32'd1);
        chk("abort_sda",   32'(bus4.sda),   32'd1);
        chk("abort_busy",  32'(bus4.busy),  32'd0);
        chk("abort_done",  32'(bus4.done),  32'd0);
        chk("abort_ready", 32'(bus4.ready), 32'd0);
        rst = 1'b0;
        tick();
        chk("abort_ready_after_rst", 32'(bus4.ready), 32'd1);
        chk("abort_no_done", 32'(dones[0]), 32'(d0));
        chk("abort_no_stop", 32'(stops[0]), 32'(p0));
        exp4.delete();
        rd4 = obs4.size();
        load_frame(0, 8'h06);
        wait_frame(0, "f6");

        load_frame(0, 8'h03);
        wait_frame(0, "b2b_3");
        load_frame(0, 8'h05);
        wait_frame(0, "b2b_5");
        repeat (10) tick();

        chk("u4_stray_edges", 32'(strays[0]), 32'd0);
        chk("u8_stray_edges", 32'(strays[1]), 32'd0);
        chk("u4_starts", 32'(starts[0]), 32'd7);
        chk("u4_stops",  32'(stops[0]),  32'd6);
        chk("u4_dones",  32'(dones[0]),  32'd6);
        chk("u8_starts", 32'(starts[1]), 32'd2);
        chk("u8_stops",  32'(stops[1]),  32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
